multicycle_ctrl: RTL and testbench

Multi-cycle FSM controller for the team's MIPS subset: LW, SW, J, JAL, BNE, XORI, R-type ADD/SUB/SLT/JR, and HALT (op 0x3f). It sequences a shared-memory datapath through fetch, decode, execute, memory and writeback, with one state per cycle. Instruction and data memory sit behind a single req/ready handshake. It replaces the per-instruction static decode with stepped control and adds halt, illegal-instruction and memory-timeout reporting.

---
 rtl/ctrl_pkg.sv | 63 ++++++
 rtl/mem_wait_timer.sv | 29 ++
 rtl/multicycle_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: opcodes, functs,
// ALU ops, FSM state codes and datapath mux selects.
package ctrl_pkg;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpXori  = 6'h0e;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2b;
    localparam logic [5:0] OpHalt  = 6'h3f;

    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnSlt = 6'h2a;

    localparam logic [2:0] AluAdd = 3'd0;
    localparam logic [2:0] AluSub = 3'd1;
    localparam logic [2:0] AluXor = 3'd2;
    localparam logic [2:0] AluSlt = 3'd3;

    typedef logic [3:0] state_t;
    localparam state_t StStart    = 4'd0;
    localparam state_t StFetch    = 4'd1;
    localparam state_t StDecode   = 4'd2;
    localparam state_t StMemAddr  = 4'd3;
    localparam state_t StMemRead  = 4'd4;
    localparam state_t StMemWb    = 4'd5;
    localparam state_t StMemWrite = 4'd6;
    localparam state_t StExecR    = 4'd7;
    localparam state_t StExecI    = 4'd8;
    localparam state_t StAluWb    = 4'd9;
    localparam state_t StBranch   = 4'd10;
    localparam state_t StJump     = 4'd11;
    localparam state_t StJal      = 4'd12;
    localparam state_t StJr       = 4'd13;
    localparam state_t StHalt     = 4'd14;

    localparam logic [1:0] PcSrcAlu    = 2'd0;
    localparam logic [1:0] PcSrcAluOut = 2'd1;
    localparam logic [1:0] PcSrcJump   = 2'd2;
    localparam logic [1:0] PcSrcReg    = 2'd3;

    localparam logic [1:0] SrcBReg   = 2'd0;
    localparam logic [1:0] SrcBFour  = 2'd1;
    localparam logic [1:0] SrcBImm   = 2'd2;
    localparam logic [1:0] SrcBImmSh = 2'd3;

    localparam logic [1:0] WbAluOut = 2'd0;
    localparam logic [1:0] WbMdr    = 2'd1;
    localparam logic [1:0] WbPc     = 2'd2;

    function automatic logic [2:0] funct_alu_op(input logic [5:0] funct);
        case (funct)
            FnSub:   return AluSub;
            FnSlt:   return AluSlt;
            default: return AluAdd;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive requested-but-not-ready memory cycles and flags expiry
// on the cycle the limit is reached without a handshake.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req,
    input  logic ready,
    output logic expire
);
    localparam int unsigned CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LIMIT   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam bit          ENABLED = (TIMEOUT_CYCLES != 0);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n || !req || ready) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // A handshake on the limit cycle wins over the timeout.
    assign expire = ENABLED && req && !ready && (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS subset: sequences fetch/decode/execute/
// memory/writeback and reports halt, illegal instruction and memory timeout.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_reset,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             jal_select,
    output logic [1:0]       wb_sel,
    output logic             halted,
    output logic             illegal,
    output logic             mem_fault,
    output logic [CNT_W-1:0] retired
);
    state_t           state_q, state_d;
    logic             rdst_q, rdst_d;
    logic             illegal_q, illegal_set;
    logic             fault_q, fault_set;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    logic             mem_access;
    logic             expire;

    assign mem_access = (state_q == StFetch) || (state_q == StMemRead) ||
                        (state_q == StMemWrite);

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .req    (mem_access),
        .ready  (mem_ready),
        .expire (expire)
    );

    always_comb begin
        mem_req    = mem_access;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_reset   = 1'b0;
        pc_source  = PcSrcAlu;
        alu_src_a  = 1'b0;
        alu_src_b  = SrcBReg;
        alu_op     = AluAdd;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        jal_select = 1'b0;
        wb_sel     = WbAluOut;
        halted     = 1'b0;
        case (state_q)
            StStart: pc_reset = 1'b1;
            StFetch: begin
                alu_src_b = SrcBFour;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            StDecode: alu_src_b = SrcBImmSh;
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
            end
            StMemRead: i_or_d = 1'b1;
            StMemWb: begin
                reg_write = 1'b1;
                wb_sel    = WbMdr;
            end
            StMemWrite: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            StExecR: begin
                alu_src_a = 1'b1;
                alu_op    = funct_alu_op(funct);
            end
            StExecI: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                alu_op    = AluXor;
            end
            StAluWb: begin
                reg_write = 1'b1;
                reg_dst   = rdst_q;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                alu_op    = AluSub;
                pc_source = PcSrcAluOut;
                pc_write  = ~zero;
            end
            StJump: begin
                pc_source = PcSrcJump;
                pc_write  = 1'b1;
            end
            StJal: begin
                pc_source  = PcSrcJump;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                jal_select = 1'b1;
                wb_sel     = WbPc;
            end
            StJr: begin
                pc_source = PcSrcReg;
                pc_write  = 1'b1;
            end
            StHalt:  halted = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rdst_d      = rdst_q;
        illegal_set = 1'b0;
        fault_set   = 1'b0;
        retire      = 1'b0;
        case (state_q)
            StStart: state_d = StFetch;
            StFetch: begin
                if (mem_ready)   state_d = StDecode;
                else if (expire) state_d = StHalt;
            end
            StDecode: begin
                case (op)
                    OpLw, OpSw: state_d = StMemAddr;
                    OpXori:     state_d = StExecI;
                    OpBne:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    OpJal:      state_d = StJal;
                    OpHalt:     state_d = StHalt;
                    OpRtype: begin
                        case (funct)
                            FnAdd, FnSub, FnSlt: state_d = StExecR;
                            FnJr:                state_d = StJr;
                            default: begin
                                state_d     = StHalt;
                                illegal_set = 1'b1;
                            end
                        endcase
                    end
                    default: begin
                        state_d     = StHalt;
                        illegal_set = 1'b1;
                    end
                endcase
            end
            StMemAddr: state_d = (op == OpSw) ? StMemWrite : StMemRead;
            StMemRead: begin
                if (mem_ready)   state_d = StMemWb;
                else if (expire) state_d = StHalt;
            end
            StMemWrite: begin
                if (mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end else if (expire) begin
                    state_d = StHalt;
                end
            end
            StExecR: begin
                state_d = StAluWb;
                rdst_d  = 1'b1;
            end
            StExecI: begin
                state_d = StAluWb;
                rdst_d  = 1'b0;
            end
            StMemWb, StAluWb, StBranch, StJump, StJal, StJr: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StHalt:  ;
            default: state_d = StStart;
        endcase
        fault_set = expire && !mem_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StStart;
            rdst_q    <= 1'b0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            rdst_q  <= rdst_d;
            if (illegal_set) illegal_q <= 1'b1;
            if (fault_set)   fault_q   <= 1'b1;
            if (retire)      retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign illegal   = illegal_q;
    assign mem_fault = fault_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-level reference model checked every
// cycle, plus directed literal checks at key cycles.
module tb_multicycle_ctrl;
    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  op = 6'h00;
    logic [5:0]  funct = 6'h00;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        mem_req, mem_write, i_or_d, ir_write, pc_write, pc_reset;
    logic [1:0]  pc_source, alu_src_b, wb_sel;
    logic        alu_src_a, reg_write, reg_dst, jal_select, halted, illegal, mem_fault;
    logic [2:0]  alu_op;
    logic [31:0] retired;

    multicycle_ctrl #(
        .TIMEOUT_CYCLES(T),
        .CNT_W         (32)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_write (mem_write),
        .i_or_d    (i_or_d),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_reset  (pc_reset),
        .pc_source (pc_source),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .reg_write (reg_write),
        .reg_dst   (reg_dst),
        .jal_select(jal_select),
        .wb_sel    (wb_sel),
        .halted    (halted),
        .illegal   (illegal),
        .mem_fault (mem_fault),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_write, i_or_d, ir_write, pc_write, pc_reset;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write, reg_dst, jal_select;
        logic [1:0] wb_sel;
        logic       halted;
    } ctl_t;

    // Model: where we are in the instruction stream, not in any state encoding.
    localparam int MStart = 0, MFetch = 1, MExec = 2, MHalt = 3;
    localparam int KLw = 0, KSw = 1, KR = 2, KXori = 3, KBne = 4, KJ = 5, KJal = 6, KJr = 7;
    localparam int KHaltOp = 8, KIll = 9;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          m_valid = 0;
    int          m_mode = MStart;
    int          m_kind = KJ;
    int          m_step = 0;
    int          m_wait = 0;
    logic        m_ill = 1'b0;
    logic        m_flt = 1'b0;
    logic [31:0] m_ret = 32'd0;

    function automatic int classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h23: return KLw;
            6'h2b: return KSw;
            6'h0e: return KXori;
            6'h05: return KBne;
            6'h02: return KJ;
            6'h03: return KJal;
            6'h3f: return KHaltOp;
            6'h00: begin
                if (f == 6'h20 || f == 6'h22 || f == 6'h2a) return KR;
                if (f == 6'h08) return KJr;
                return KIll;
            end
            default: return KIll;
        endcase
    endfunction

    // Cycles after decode: LW 5 total, SW/R/XORI 4, the rest 3.
    function automatic int last_step(input int k);
        if (k == KLw) return 4;
        if (k == KSw || k == KR || k == KXori) return 3;
        return 2;
    endfunction

    function automatic ctl_t exp_ctl(input int mode, input int kind, input int step,
                                     input logic rdy, input logic z, input logic [5:0] fn);
        ctl_t c;
        c = '0;
        if (mode == MStart) c.pc_reset = 1'b1;
        else if (mode == MHalt) c.halted = 1'b1;
        else if (mode == MFetch) begin
            c.mem_req = 1'b1; c.alu_src_b = 2'd1; c.ir_write = rdy; c.pc_write = rdy;
        end else if (step == 1) begin
            c.alu_src_b = 2'd3;
        end else begin
            case (kind)
                KLw, KSw: begin
                    if (step == 2) begin
                        c.alu_src_a = 1'b1; c.alu_src_b = 2'd2;
                    end else if (step == 3) begin
                        c.mem_req = 1'b1; c.i_or_d = 1'b1; c.mem_write = (kind == KSw);
                    end else begin
                        c.reg_write = 1'b1; c.wb_sel = 2'd1;
                    end
                end
                KR: begin
                    if (step == 2) begin
                        c.alu_src_a = 1'b1;
                        c.alu_op = (fn == 6'h22) ? 3'd1 : (fn == 6'h2a) ? 3'd3 : 3'd0;
                    end else begin
                        c.reg_write = 1'b1; c.reg_dst = 1'b1;
                    end
                end
                KXori: begin
                    if (step == 2) begin
                        c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_op = 3'd2;
                    end else begin
                        c.reg_write = 1'b1;
                    end
                end
                KBne: begin
                    c.alu_src_a = 1'b1; c.alu_op = 3'd1; c.pc_source = 2'd1; c.pc_write = ~z;
                end
                KJ: begin
                    c.pc_source = 2'd2; c.pc_write = 1'b1;
                end
                KJal: begin
                    c.pc_source = 2'd2; c.pc_write = 1'b1; c.reg_write = 1'b1;
                    c.jal_select = 1'b1; c.wb_sel = 2'd2;
                end
                KJr: begin
                    c.pc_source = 2'd3; c.pc_write = 1'b1;
                end
                default: ;
            endcase
        end
        return c;
    endfunction

    task automatic mem_wait_step(output bit done);
        done = 1'b0;
        if (mem_ready) begin
            m_wait = 0;
            done = 1'b1;
        end else if (m_wait + 1 == T) begin
            m_mode = MHalt; m_flt = 1'b1; m_wait = 0;
        end else begin
            m_wait++;
        end
    endtask

    task automatic model_advance();
        bit done;
        if (!reset_n) begin
            m_mode = MStart; m_ill = 1'b0; m_flt = 1'b0; m_ret = 32'd0; m_wait = 0;
        end else if (m_mode == MStart) begin
            m_mode = MFetch; m_wait = 0;
        end else if (m_mode == MFetch) begin
            mem_wait_step(done);
            if (done) begin
                m_mode = MExec; m_step = 1;
            end
        end else if (m_mode == MExec) begin
            if (m_step == 1) begin
                m_kind = classify(op, funct);
                if (m_kind == KHaltOp) m_mode = MHalt;
                else if (m_kind == KIll) begin
                    m_mode = MHalt; m_ill = 1'b1;
                end else m_step = 2;
            end else begin
                done = 1'b1;
                if ((m_kind == KLw || m_kind == KSw) && m_step == 3) mem_wait_step(done);
                if (done) begin
                    if (m_step == last_step(m_kind)) begin
                        m_mode = MFetch; m_ret = m_ret + 32'd1;
                    end else m_step++;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        ctl_t got, want;
        cyc++;
        if (m_valid) begin
            got = {mem_req, mem_write, i_or_d, ir_write, pc_write, pc_reset, pc_source,
                   alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, jal_select, wb_sel, halted};
            want = exp_ctl(m_mode, m_kind, m_step, mem_ready, zero, funct);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL ctrl cyc=%0d got=%h expected=%h", cyc, got, want);
            end
            checks++;
            if ({illegal, mem_fault, retired} !== {m_ill, m_flt, m_ret}) begin
                errors++;
                $display("FAIL status cyc=%0d got ill=%0b flt=%0b ret=%0d expected ill=%0b flt=%0b ret=%0d",
                         cyc, illegal, mem_fault, retired, m_ill, m_flt, m_ret);
            end
        end
        model_advance();
        m_valid = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from its FETCH cycle with mem_ready held high.
    task automatic run(input logic [5:0] o, input logic [5:0] f, input int lat);
        op = o; funct = f; mem_ready = 1'b1;
        repeat (lat) next();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("start_pc_reset", 32'(pc_reset), 32'd1);
        chk("start_mem_req", 32'(mem_req), 32'd0);
        next();
        chk("fetch_mem_req", 32'(mem_req), 32'd1);
        chk("fetch_retired", retired, 32'd0);
        chk("fetch_halted", 32'(halted), 32'd0);

        op = 6'h23; repeat (4) next();
        chk("lw_c5_reg_write", 32'(reg_write), 32'd1);
        chk("lw_c5_wb_sel", 32'(wb_sel), 32'd1);
        next();
        chk("lw_retired", retired, 32'd1);

        op = 6'h05; zero = 1'b0; next(); next();
        chk("bne_nz_pc_write", 32'(pc_write), 32'd1);
        chk("bne_nz_pc_source", 32'(pc_source), 32'd1);
        next();
        zero = 1'b1; next(); next();
        chk("bne_z_pc_write", 32'(pc_write), 32'd0);
        next();
        zero = 1'b0;

        op = 6'h03; next(); next();
        chk("jal_pc_write", 32'(pc_write), 32'd1);
        chk("jal_reg_write", 32'(reg_write), 32'd1);
        chk("jal_select", 32'(jal_select), 32'd1);
        chk("jal_wb_sel", 32'(wb_sel), 32'd2);
        next();
        op = 6'h00; funct = 6'h08; next(); next();
        chk("jr_pc_source", 32'(pc_source), 32'd3);
        chk("jr_reg_write", 32'(reg_write), 32'd0);
        chk("jr_pc_write", 32'(pc_write), 32'd1);
        next();
        chk("retired_5", retired, 32'd5);

        run(6'h00, 6'h20, 4);
        run(6'h00, 6'h22, 4);
        run(6'h00, 6'h2a, 4);
        run(6'h0e, 6'h00, 4);
        run(6'h02, 6'h00, 3);
        run(6'h2b, 6'h00, 4);
        chk("retired_11", retired, 32'd11);

        // LW with two memory wait cycles: 7 cycles total.
        op = 6'h23; next(); next();
        mem_ready = 1'b0; next(); next(); next();
        mem_ready = 1'b1; next(); next();
        chk("lw_wait_retired", retired, 32'd12);
        chk("lw_wait_fetch", 32'(mem_req & ~i_or_d), 32'd1);

        // Fetch handshake arrives exactly on the limit cycle.
        op = 6'h02; mem_ready = 1'b0; next(); next(); next();
        mem_ready = 1'b1; next();
        chk("limit_ready_wins", 32'(mem_fault), 32'd0);
        next(); next();
        chk("retired_13", retired, 32'd13);

        // SW timeout after four unanswered MEMWRITE cycles.
        op = 6'h2b; next(); next();
        mem_ready = 1'b0; repeat (4) next();
        chk("sw_to_mem_write", 32'(mem_write), 32'd1);
        chk("sw_to_no_fault_yet", 32'(mem_fault), 32'd0);
        next();
        chk("sw_to_halted", 32'(halted), 32'd1);
        chk("sw_to_fault", 32'(mem_fault), 32'd1);
        chk("sw_to_retired", retired, 32'd13);
        mem_ready = 1'b1; next(); next();
        chk("halt_sticky", 32'(halted), 32'd1);
        reset_n = 1'b0; next();
        chk("rst_clr_halted", 32'(halted), 32'd0);
        chk("rst_clr_fault", 32'(mem_fault), 32'd0);
        chk("rst_clr_retired", retired, 32'd0);
        reset_n = 1'b1; next();

        run(6'h02, 6'h00, 3);
        op = 6'h3f; next(); next();
        chk("haltop_halted", 32'(halted), 32'd1);
        chk("haltop_retired", retired, 32'd1);
        chk("haltop_not_illegal", 32'(illegal), 32'd0);
        next();

        reset_n = 1'b0; next(); reset_n = 1'b1; next();
        op = 6'h11; next(); next();
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_halted", 32'(halted), 32'd1);
        reset_n = 1'b0; next();
        chk("rst_clr_illegal", 32'(illegal), 32'd0);
        reset_n = 1'b1; next();

        op = 6'h00; funct = 6'h20; next(); next();
        chk("execr_src_a", 32'(alu_src_a), 32'd1);
        reset_n = 1'b0; next();
        chk("abort_pc_reset", 32'(pc_reset), 32'd1);
        chk("abort_reg_write", 32'(reg_write), 32'd0);
        reset_n = 1'b1; next(); next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
